// File: rtl/hpi_bus_bridge.sv
// Turns level-style HPI requests from software PIOs into one timed CY7C67200 HPI bus cycle.
// Optional `HPI_BRIDGE_ERR_EN adds a sticky err flag for requests with both strobes low.
module hpi_bus_bridge #(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  hpi_address,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic [15:0] hpi_wdata,
  output logic [15:0] hpi_rdata,
  output logic        busy,
`ifdef HPI_BRIDGE_ERR_EN
  output logic        err,
`endif
  output logic [1:0]  OTG_ADDR,
  output logic        OTG_CS_N,
  output logic        OTG_RD_N,
  output logic        OTG_WR_N,
  inout  wire  [15:0] OTG_DATA
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        arm_reg, arm_next;
  logic        is_wr_reg, is_wr_next;
  logic [1:0]  addr_reg;
  logic [15:0] wdata_reg;
  logic [15:0] rdata_reg;
  logic        busy_reg, busy_next;
  logic        cs_n_reg, cs_n_next;
  logic        rd_n_reg, rd_n_next;
  logic        wr_n_reg, wr_n_next;
  logic        oe_reg, oe_next;
  logic        accept;
  logic        capture;
  logic        req_legal;
  logic        cyc_active;

  assign req_legal = !hpi_cs_n && (hpi_r_n ^ hpi_w_n);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    arm_next   = arm_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Re-arming needs the request to be dropped; a held level never repeats.
        if (hpi_cs_n || (hpi_r_n && hpi_w_n))
          arm_next = 1'b1;
        if (arm_reg && req_legal) begin
          accept     = 1'b1;
          arm_next   = 1'b0;
          state_next = SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_reg == 4'd0) begin
          state_next = STROBE;
          cnt_next   = STROBE_LD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_reg == 4'd0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
          capture    = !is_wr_reg;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_reg == 4'd0) begin
          state_next = RECOVER;
          cnt_next   = RECOVER_LD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RECOVER: begin
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Pin registers are computed from the next state so every pin is a flop output.
  always_comb begin
    is_wr_next = accept ? !hpi_w_n : is_wr_reg;
    cyc_active = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
    cs_n_next  = !cyc_active;
    rd_n_next  = !((state_next == STROBE) && !is_wr_next);
    wr_n_next  = !((state_next == STROBE) && is_wr_next);
    oe_next    = cyc_active && is_wr_next;
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      arm_reg   <= 1'b0;
      is_wr_reg <= 1'b0;
      addr_reg  <= 2'd0;
      wdata_reg <= 16'd0;
      rdata_reg <= 16'd0;
      busy_reg  <= 1'b0;
      cs_n_reg  <= 1'b1;
      rd_n_reg  <= 1'b1;
      wr_n_reg  <= 1'b1;
      oe_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      arm_reg   <= arm_next;
      is_wr_reg <= is_wr_next;
      busy_reg  <= busy_next;
      cs_n_reg  <= cs_n_next;
      rd_n_reg  <= rd_n_next;
      wr_n_reg  <= wr_n_next;
      oe_reg    <= oe_next;
      if (accept) begin
        addr_reg  <= hpi_address;
        wdata_reg <= hpi_wdata;
      end
      if (capture)
        rdata_reg <= OTG_DATA;
    end
  end

`ifdef HPI_BRIDGE_ERR_EN
  logic err_reg;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      err_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (hpi_cs_n)
        err_reg <= 1'b0;
      else if (!hpi_r_n && !hpi_w_n)
        err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

  assign hpi_rdata = rdata_reg;
  assign busy      = busy_reg;
  assign OTG_ADDR  = addr_reg;
  assign OTG_CS_N  = cs_n_reg;
  assign OTG_RD_N  = rd_n_reg;
  assign OTG_WR_N  = wr_n_reg;
  assign OTG_DATA  = oe_reg ? wdata_reg : 16'bz;

endmodule

// File: tb/tb_hpi_bus_bridge.sv
// Scoreboard bench for hpi_bus_bridge: stimulus pushes expected bus cycles, a negedge monitor
// measures each completed cycle on the pins and compares it against the queue head.
module tb_hpi_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  addr;
  logic        cs_n, r_n, w_n;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic [1:0]  otg_addr;
  logic        otg_cs_n, otg_rd_n, otg_wr_n;
  wire  [15:0] otg_data;
  logic [15:0] tb_val;

  logic [1:0]  addr_min;
  logic        cs_n_min, r_n_min, w_n_min;
  logic [15:0] wdata_min;
  logic [15:0] rdata_min;
  logic        busy_min;
  logic [1:0]  otg_addr_min;
  logic        otg_cs_n_min, otg_rd_n_min, otg_wr_n_min;
  wire  [15:0] otg_data_min;

`ifdef HPI_BRIDGE_ERR_EN
  logic err, err_min;
`endif

  // Emulated CY7C67200: drives the data bus only while the read strobe is low.
  assign otg_data = (!otg_rd_n) ? tb_val : 16'bz;

  hpi_bus_bridge u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .hpi_address(addr), .hpi_cs_n(cs_n),
    .hpi_r_n(r_n), .hpi_w_n(w_n), .hpi_wdata(wdata), .hpi_rdata(rdata), .busy(busy),
`ifdef HPI_BRIDGE_ERR_EN
    .err(err),
`endif
    .OTG_ADDR(otg_addr), .OTG_CS_N(otg_cs_n), .OTG_RD_N(otg_rd_n), .OTG_WR_N(otg_wr_n),
    .OTG_DATA(otg_data)
  );

  hpi_bus_bridge #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1)) u_min (
    .clk_clk(clk), .reset_reset_n(rst_n), .hpi_address(addr_min), .hpi_cs_n(cs_n_min),
    .hpi_r_n(r_n_min), .hpi_w_n(w_n_min), .hpi_wdata(wdata_min), .hpi_rdata(rdata_min),
    .busy(busy_min),
`ifdef HPI_BRIDGE_ERR_EN
    .err(err_min),
`endif
    .OTG_ADDR(otg_addr_min), .OTG_CS_N(otg_cs_n_min), .OTG_RD_N(otg_rd_n_min),
    .OTG_WR_N(otg_wr_n_min), .OTG_DATA(otg_data_min)
  );

  typedef struct packed {
    logic        is_wr;
    logic [1:0]  addr;
    logic [15:0] data;   // write data, or a value the DUT must never drive during a read
    logic [15:0] rdata;  // hpi_rdata expected while the cycle completes
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Monitor accumulators
  int          m_busy = 0, m_cs = 0, m_setup = 0, m_str = 0, m_rd_p = 0, m_wr_p = 0, m_data_bad = 0;
  logic        m_prev_busy = 1'b0, m_prev_rd = 1'b1, m_prev_wr = 1'b1, m_seen_str = 1'b0;
  logic [1:0]  m_addr = 2'd0;
  logic [15:0] m_rdata_last = 16'd0;
  exp_t        m_e;

  task automatic mon_clear();
    m_busy = 0; m_cs = 0; m_setup = 0; m_str = 0; m_rd_p = 0; m_wr_p = 0; m_data_bad = 0;
    m_seen_str = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_clear();
      m_prev_busy = 1'b0;
      m_prev_rd   = 1'b1;
      m_prev_wr   = 1'b1;
    end else begin
      if (busy) begin
        m_busy++;
        if (!otg_cs_n) begin
          if (m_cs == 0) m_addr = otg_addr;
          m_cs++;
          if (!m_seen_str && otg_rd_n && otg_wr_n) m_setup++;
        end
        if (!otg_rd_n || !otg_wr_n) begin
          m_seen_str = 1'b1;
          m_str++;
        end
        if (!otg_rd_n && m_prev_rd) m_rd_p++;
        if (!otg_wr_n && m_prev_wr) m_wr_p++;
        if (sb_q.size() > 0 && !otg_cs_n) begin
          if (sb_q[0].is_wr && otg_data !== sb_q[0].data) m_data_bad++;
          if (!sb_q[0].is_wr && otg_rd_n && otg_data === sb_q[0].data) m_data_bad++;
        end
        m_rdata_last = rdata;
      end else if (m_prev_busy) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_cycle: got=bus cycle want=none queued");
        end else begin
          m_e = sb_q.pop_front();
          $display("cycle done: %s addr=%0d busy=%0d setup=%0d strobe=%0d cs=%0d rdata=%h",
                   m_e.is_wr ? "write" : "read", m_addr, m_busy, m_setup, m_str, m_cs, m_rdata_last);
          check("cyc_busy_len",   m_busy,  10);
          check("cyc_setup_len",  m_setup, 2);
          check("cyc_strobe_len", m_str,   4);
          check("cyc_cs_len",     m_cs,    8);
          check("cyc_addr",       m_addr,  m_e.addr);
          check("cyc_rd_pulses",  m_rd_p,  m_e.is_wr ? 0 : 1);
          check("cyc_wr_pulses",  m_wr_p,  m_e.is_wr ? 1 : 0);
          check("cyc_data_bus",   m_data_bad, 0);
          check("cyc_rdata",      m_rdata_last, m_e.rdata);
        end
        mon_clear();
      end
      m_prev_busy = busy;
      m_prev_rd   = otg_rd_n;
      m_prev_wr   = otg_wr_n;
    end
  end

  function automatic logic get_sig(input int which);
    case (which)
      0:       return busy;
      1:       return busy_min;
      2:       return otg_wr_n;
      default: return otg_cs_n_min;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic lvl, input int budget, input string name);
    int n = 0;
    while (get_sig(which) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL %s: got=timeout after %0d cycles want=level %0b", name, n, lvl);
    end
  endtask

  task automatic idle_req();
    cs_n = 1'b1; r_n = 1'b1; w_n = 1'b1;
  endtask

  task automatic count_busy_min(input string name);
    int n = 0;
    while (busy_min && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, n, 4);
  endtask

  int n_act;
  int t_fall, t_cs;

  initial begin
    rst_n = 1'b0; addr = 2'd0; wdata = 16'd0; tb_val = 16'hBEEF;
    idle_req();
    addr_min = 2'd0; wdata_min = 16'd0; cs_n_min = 1'b1; r_n_min = 1'b1; w_n_min = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n",  otg_cs_n, 1);
    check("rst_rd_n",  otg_rd_n, 1);
    check("rst_wr_n",  otg_wr_n, 1);
    check("rst_addr",  otg_addr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy",  busy, 0);
`ifdef HPI_BRIDGE_ERR_EN
    check("rst_err", err, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write with the request held well past completion
    sb_q.push_back('{1'b1, 2'd2, 16'h1234, 16'h0000});
    addr = 2'd2; wdata = 16'h1234; cs_n = 1'b0; w_n = 1'b0;
    wait_sig(0, 1'b1, 20, "wr_busy_rise");
    wait_sig(0, 1'b0, 20, "wr_busy_fall");
    n_act = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy || !otg_cs_n) n_act++;
    end
    check("wr_held_single_cycle", n_act, 0);
    idle_req();
    repeat (2) @(negedge clk);

    // Read: DUT must sample 0xBEEF and never drive its stale write data
    sb_q.push_back('{1'b0, 2'd0, 16'hA5A5, 16'hBEEF});
    addr = 2'd0; wdata = 16'hA5A5; tb_val = 16'hBEEF; cs_n = 1'b0; r_n = 1'b0;
    wait_sig(0, 1'b1, 20, "rd_busy_rise");
    wait_sig(0, 1'b0, 20, "rd_busy_fall");
    check("rd_rdata_after", rdata, 16'hBEEF);
    idle_req();
    repeat (2) @(negedge clk);

    // Write must not disturb captured read data
    sb_q.push_back('{1'b1, 2'd1, 16'h5555, 16'hBEEF});
    addr = 2'd1; wdata = 16'h5555; cs_n = 1'b0; w_n = 1'b0;
    wait_sig(0, 1'b1, 20, "wr2_busy_rise");
    wait_sig(0, 1'b0, 20, "wr2_busy_fall");
    check("wr2_keeps_rdata", rdata, 16'hBEEF);
    idle_req();
    repeat (2) @(negedge clk);

    // Re-arm: two held read levels give exactly two bus cycles
    sb_q.push_back('{1'b0, 2'd3, 16'hA5A5, 16'hC0DE});
    addr = 2'd3; wdata = 16'hA5A5; tb_val = 16'hC0DE; cs_n = 1'b0; r_n = 1'b0;
    repeat (30) @(negedge clk);
    idle_req();
    repeat (2) @(negedge clk);
    sb_q.push_back('{1'b0, 2'd3, 16'hA5A5, 16'h0F0F});
    tb_val = 16'h0F0F; cs_n = 1'b0; r_n = 1'b0;
    repeat (30) @(negedge clk);
    idle_req();
    repeat (3) @(negedge clk);
    check("rearm_both_cycles_seen", sb_q.size(), 0);

    // Reset during the write strobe
    addr = 2'd2; wdata = 16'h7777; cs_n = 1'b0; w_n = 1'b0;
    wait_sig(2, 1'b0, 20, "rst_wr_strobe_seen");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_cs_n", otg_cs_n, 1);
    check("midrst_rd_n", otg_rd_n, 1);
    check("midrst_wr_n", otg_wr_n, 1);
    check("midrst_busy", busy, 0);
    check("midrst_data_released", otg_data === 16'h7777, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_act = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || !otg_cs_n || !otg_wr_n) n_act++;
    end
    check("midrst_no_restart", n_act, 0);
    idle_req();
    repeat (2) @(negedge clk);

    // Illegal request: both strobes low
    cs_n = 1'b0; r_n = 1'b0; w_n = 1'b0;
    n_act = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || !otg_cs_n || !otg_rd_n || !otg_wr_n) n_act++;
    end
    check("illegal_no_activity", n_act, 0);
`ifdef HPI_BRIDGE_ERR_EN
    check("illegal_err_set", err, 1);
    idle_req();
    @(negedge clk);
    check("illegal_err_clear", err, 0);
`endif
    idle_req();
    repeat (2) @(negedge clk);

    // Minimum timing instance: back-to-back write then read
    wdata_min = 16'h1111; addr_min = 2'd1; cs_n_min = 1'b0; w_n_min = 1'b0;
    wait_sig(1, 1'b1, 20, "min_wr_busy_rise");
    count_busy_min("min_wr_busy_len");
    t_fall = cyc;
    cs_n_min = 1'b1; w_n_min = 1'b1;
    @(negedge clk);
    cs_n_min = 1'b0; r_n_min = 1'b0;
    wait_sig(3, 1'b0, 20, "min_rd_cs_fall");
    t_cs = cyc;
    check("min_gap_after_busy", (t_cs - t_fall) >= 1, 1);
    count_busy_min("min_rd_busy_len");
    cs_n_min = 1'b1; r_n_min = 1'b1;
    repeat (3) @(negedge clk);

    check("sb_leftover", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpi_bus_bridge.md
# hpi_bus_bridge

Sits between the Nios system's software-driven OTG HPI PIO exports and the CY7C67200 HPI pins on the board. Converts level-style requests into one correctly timed HPI bus cycle: setup, strobe, hold and recovery counts, with read-data capture and data-bus tristate control. Software polls `busy` through a hardware-signal PIO bit and never bit-bangs HPI timing itself.

## Interface
Parameters:
- `SETUP_CYC`, default 2: cycles from address/CS assertion to strobe assertion. Legal range 1..15.
- `STROBE_CYC`, default 4: cycles the RD_N or WR_N strobe is held low. Legal range 1..15.
- `HOLD_CYC`, default 2: cycles after strobe release with CS, address and write data still held. Legal range 1..15.
- `RECOVER_CYC`, default 2: cycles with CS released before the next request can be accepted. Legal range 1..15.

Ports:
- `clk_clk` in 1: system clock.
- `reset_reset_n` in 1: synchronous, active-low reset.
- `hpi_address` in 2: HPI register select from `otg_hpi_address_export`.
- `hpi_cs_n` in 1: request chip select, active low.
- `hpi_r_n` in 1: read request, active low.
- `hpi_w_n` in 1: write request, active low.
- `hpi_wdata` in 16: write data from `otg_hpi_data_out_port`.
- `hpi_rdata` out 16: captured read data, feeding `otg_hpi_data_in_port`.
- `busy` out 1: cycle in progress.
- `OTG_ADDR` out 2: HPI address pins.
- `OTG_CS_N` out 1: HPI chip select.
- `OTG_RD_N` out 1: HPI read strobe.
- `OTG_WR_N` out 1: HPI write strobe.
- `OTG_DATA` inout 16: HPI data bus.

## Operation
- All outputs are registered. There are no combinational paths from inputs to pins.
- The FSM states are IDLE, SETUP, STROBE, HOLD and RECOVER.
- **Arm flag:** set in IDLE whenever `hpi_cs_n`=1 or both `hpi_r_n` and `hpi_w_n` are 1. It is cleared on accept and on reset. One request level yields exactly one bus cycle.
- **Accept rule:** in IDLE with arm=1, `hpi_cs_n`=0 and exactly one of `hpi_r_n`/`hpi_w_n` low:
  - latch the address, direction and `hpi_wdata`;
  - go to SETUP;
  - set `busy`=1.
- **Both strobes low:** the request is ignored. The FSM stays in IDLE and arm is unchanged.
- **SETUP:**
  - `OTG_CS_N`=0 and `OTG_ADDR` = latched address.
  - For a write, `OTG_DATA` is driven with the latched data. For a read, `OTG_DATA` is Z.
- **STROBE:** `OTG_RD_N`=0 (read) or `OTG_WR_N`=0 (write). On the final STROBE cycle of a read, `OTG_DATA` is sampled into `hpi_rdata`.
- **HOLD:** both strobes are 1. CS, address and write data are unchanged.
- **RECOVER:** `OTG_CS_N`=1 and `OTG_DATA` is Z. The FSM then returns to IDLE and `busy` drops.
- **State counter:** 4-bit, loaded with N-1 on state entry, decrements, and advances at 0.
- **Read data:** `hpi_rdata` holds its value until the next read capture. Writes never alter it.
- **Request changes after accept:** changes to the request inputs are ignored until the FSM is back in IDLE.

## Timing
- **Reset values:**
  - `OTG_CS_N`=1, `OTG_RD_N`=1, `OTG_WR_N`=1;
  - `OTG_ADDR`=0, `OTG_DATA`=Z;
  - `hpi_rdata`=0, `busy`=0;
  - state IDLE, arm=0.
- **Reset mid-cycle:** all pins return to the reset values at the next edge. A request still held does not re-execute until software releases it (arm=0).
- **Accept edge:** the edge at which the accept rule holds is edge 0.
  - `busy`, `OTG_CS_N`=0 and the address appear after edge 0.
  - The strobe asserts after edge `SETUP_CYC`.
  - The strobe deasserts after edge `SETUP_CYC+STROBE_CYC`.
  - CS releases after edge `SETUP_CYC+STROBE_CYC+HOLD_CYC`.
  - `busy`=0 after edge `SETUP_CYC+STROBE_CYC+HOLD_CYC+RECOVER_CYC`. With defaults this is 10 cycles.
- **Read-data latency:** `hpi_rdata` is valid after edge `SETUP_CYC+STROBE_CYC`, so it is stable before `busy` falls.
- **Back-to-back requests:** the earliest next accept is the cycle after `busy` falls, provided arm has been re-set.

## Configuration
- Macro: `HPI_BRIDGE_ERR_EN`.
- **Defined:**
  - adds output `err` (1 bit), reset 0;
  - `err` is set when both `hpi_r_n` and `hpi_w_n` are low with `hpi_cs_n`=0 in IDLE;
  - `err` is sticky and clears when `hpi_cs_n`=1 in IDLE.
- **Undefined:** there is no `err` port, and the illegal request is silently ignored.

## Test plan
- **Write, defaults:** address=2, `hpi_wdata`=0x1234, cs/w held low. Required: `OTG_WR_N` is low for exactly 4 cycles starting 2 cycles after CS; `OTG_DATA`=0x1234 throughout CS low; `busy` is high for 10 cycles; exactly one strobe occurs despite the held request.
- **Read:** the bench drives `OTG_DATA`=0xBEEF during STROBE, address=0. Required: `hpi_rdata`=0xBEEF before `busy` falls, `OTG_DATA` is never driven by the DUT, and `hpi_rdata` is unchanged after a later write of 0x5555.
- **Re-arm:** hold a read request for 30 cycles, then release and reassert it. Required: exactly two RD_N pulses in total.
- **Reset during STROBE of a write:** required: CS/RD/WR go to 1 and `OTG_DATA` to Z at the next edge. With the request still held, no new cycle starts until cs is released.
- **Illegal request:** cs=0, r=0, w=0. Required: no pin activity and `busy`=0. With `HPI_BRIDGE_ERR_EN` defined, `err`=1 until cs=1.
- **Parameters at minimums:** all four set to 1, back-to-back write then read. Required: each cycle lasts 4 cycles, and the second CS falls no earlier than 1 cycle after `busy` drops.
